// File: rtl/i_line_fill_pkg.sv
// Shared definitions for the instruction-cache line-fill engine: FSM encoding,
// line geometry and the address slicing agreed with the cache.
package i_line_fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_COOL = 2'd3
    } fill_state_e;

    localparam int LINE_WORDS  = 4;
    localparam int WORD_W      = 32;
    localparam int LINE_W      = LINE_WORDS * WORD_W;
    localparam int ADDR_W      = 32;
    localparam int CNT_W       = 2;

    // Cache address split: tag | block index | byte offset within line
    localparam int TAG_W       = 20;
    localparam int BLOCK_W     = 8;
    localparam int OFFSET_W    = 4;
    localparam int LINE_ADDR_W = ADDR_W - OFFSET_W;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [LINE_ADDR_W-1:0] line,
                                                   input logic [CNT_W-1:0]       cnt);
        return {line, cnt, 2'b00};
    endfunction

endpackage

// File: rtl/i_line_fill_if.sv
// Cache-side fill request/response plus the word-wide req/ack memory bus.
// slave = the fill engine, master = the cache and memory around it.
interface i_line_fill_if;
    import i_line_fill_pkg::*;

    logic                mem_r;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ready;
    logic [LINE_W-1:0]   mem_data;
    logic                fill_err;
    logic                busy;

    logic                bus_req;
    logic [ADDR_W-1:0]   bus_addr;
    logic                bus_ack;
    logic [WORD_W-1:0]   bus_rdata;

    modport slave (
        input  mem_r, mem_addr, bus_ack, bus_rdata,
        output mem_ready, mem_data, fill_err, busy, bus_req, bus_addr
    );

    modport master (
        output mem_r, mem_addr, bus_ack, bus_rdata,
        input  mem_ready, mem_data, fill_err, busy, bus_req, bus_addr
    );

endinterface

// File: rtl/i_line_fill_timer.sv
// Per-word bus wait counter; expired flags the enabled cycle on which the count
// reaches TIMEOUT. Single cycle, no backpressure.
module i_line_fill_timer #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the wait cycle that makes the count equal TIMEOUT, so the bus
    // request is held for exactly TIMEOUT unanswered cycles.
    assign expired = en && (count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/i_line_fill.sv
// Fetches a 4-word line over a req/ack bus and delivers it as one 128-bit beat.
// Latency 6 cycles with a zero-wait bus; each bus wait adds one; per-word timeout.
module i_line_fill
    import i_line_fill_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    i_line_fill_if.slave  fill
);

    fill_state_e              state, state_nxt;
    logic [LINE_ADDR_W-1:0]   line_q, line_nxt;
    logic [CNT_W-1:0]         cnt_q, cnt_nxt;
    logic [LINE_W-1:0]        asm_q, asm_nxt;
    logic [LINE_W-1:0]        mem_data_q;
    logic                     fill_err_q;
    logic                     load_out;
    logic                     err_nxt;
    logic                     tmr_clr;
    logic                     tmr_en;
    logic                     tmr_expired;
    logic                     unused_addr_bits;

    assign unused_addr_bits = ^fill.mem_addr[OFFSET_W-1:0];

    i_line_fill_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_fill_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_nxt = state;
        line_nxt  = line_q;
        cnt_nxt   = cnt_q;
        asm_nxt   = asm_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        load_out  = 1'b0;
        err_nxt   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (fill.mem_r) begin
                    line_nxt  = fill.mem_addr[ADDR_W-1:OFFSET_W];
                    cnt_nxt   = '0;
                    asm_nxt   = '0;
                    tmr_clr   = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (fill.bus_ack) begin
                    asm_nxt[{cnt_q, 5'b00000} +: WORD_W] = fill.bus_rdata;
                    tmr_clr = 1'b1;
                    if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
                        load_out  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        // Unfilled slots stay zero from the clear at accept.
                        load_out  = 1'b1;
                        err_nxt   = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: state_nxt = ST_COOL;
            // Lets the cache's registered view of mem_ready drop mem_r first.
            ST_COOL: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            line_q     <= '0;
            cnt_q      <= '0;
            asm_q      <= '0;
            mem_data_q <= '0;
            fill_err_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            line_q <= line_nxt;
            cnt_q  <= cnt_nxt;
            asm_q  <= asm_nxt;
            // Output line only changes on entry to DONE, so it stays stable
            // while the next fill assembles in asm_q.
            if (load_out) begin
                mem_data_q <= asm_nxt;
                fill_err_q <= err_nxt;
            end
        end
    end

    assign fill.mem_ready = (state == ST_DONE);
    assign fill.mem_data  = mem_data_q;
    assign fill.fill_err  = fill_err_q;
    assign fill.busy      = (state != ST_IDLE);
    assign fill.bus_req   = (state == ST_REQ);
    assign fill.bus_addr  = (state == ST_REQ) ? word_addr(line_q, cnt_q) : '0;

endmodule

// File: tb/tb_i_line_fill.sv
// Directed and randomized line fills against a cycle-count/line reference model.
module tb_i_line_fill;
    import i_line_fill_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int TO_W    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i_line_fill_if fif ();

    i_line_fill #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .fill (fif.slave)
    );

    int           errs   = 0;
    int           checks = 0;
    logic [127:0] last_line = '0;
    int           wv[4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One fill: memory waits wv[k] cycles before acking word k; a wait of
    // TIMEOUT or more is never answered. Starts and ends just after a negedge.
    task automatic do_fill(input logic [31:0] addr, input logic [31:0] salt, input bit drop);
        logic [127:0] line;
        logic [31:0]  wa;
        bit           err;
        bit           seen;
        int           reqc;
        int           cyc;
        int           word;
        int           waited;
        int           nreq;
        line = '0;
        err  = 1'b0;
        reqc = 0;
        for (int i = 0; i < 4; i++) begin
            if (wv[i] >= TIMEOUT) begin
                reqc += TIMEOUT;
                err = 1'b1;
                break;
            end
            reqc += wv[i] + 1;
            line[i*32 +: 32] = {addr[31:4], i[1:0], 2'b00} ^ salt;
        end

        fif.mem_r    = 1'b1;
        fif.mem_addr = addr;
        fif.bus_ack  = 1'b0;
        cyc = 1; word = 0; waited = 0; nreq = 0; seen = 1'b0;
        @(posedge clk);
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (drop) fif.mem_r = 1'b0;
            fif.bus_ack = 1'b0;
            if (fif.mem_ready) begin
                seen = 1'b1;
            end else begin
                chk("line_stable", fif.mem_data, last_line);
                if (fif.bus_req) begin
                    nreq++;
                    wa = {addr[31:4], word[1:0], 2'b00};
                    chk("bus_addr", 128'(fif.bus_addr), 128'(wa));
                    if (word < 4 && waited >= wv[word]) begin
                        fif.bus_ack   = 1'b1;
                        fif.bus_rdata = wa ^ salt;
                        word++;
                        waited = 0;
                    end else begin
                        waited++;
                    end
                end
            end
        end
        chk("ready_seen", 128'(seen), 128'(1));
        chk("latency", 128'(cyc), 128'(reqc + 2));
        chk("req_cycles", 128'(nreq), 128'(reqc));
        chk("req_low_done", 128'(fif.bus_req), 128'(0));
        chk("mem_data", fif.mem_data, line);
        chk("fill_err", 128'(fif.fill_err), 128'(err));
        last_line = line;
        fif.bus_ack = 1'b0;
    endtask

    // DONE -> COOL -> IDLE; optional spurious acks while the bus is idle.
    task automatic post_fill(input bit hold, input bit spur);
        fif.mem_r     = hold;
        fif.bus_ack   = spur;
        fif.bus_rdata = $urandom;
        @(negedge clk);
        chk("cool_busy", 128'(fif.busy), 128'(1));
        chk("cool_req", 128'(fif.bus_req), 128'(0));
        chk("cool_ready", 128'(fif.mem_ready), 128'(0));
        chk("cool_data", fif.mem_data, last_line);
        fif.bus_ack = spur;
        @(negedge clk);
        chk("idle_busy", 128'(fif.busy), 128'(0));
        chk("idle_req", 128'(fif.bus_req), 128'(0));
        if (!hold) begin
            @(negedge clk);
            chk("idle_stay", 128'(fif.busy), 128'(0));
            chk("idle_data", fif.mem_data, last_line);
        end
        fif.bus_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] s;
        bit          hold;
        bit          drop;

        fif.mem_r     = 1'b0;
        fif.mem_addr  = '0;
        fif.bus_ack   = 1'b0;
        fif.bus_rdata = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_ready", 128'(fif.mem_ready), 128'(0));
        chk("rst_data", fif.mem_data, 128'(0));
        chk("rst_err", 128'(fif.fill_err), 128'(0));
        chk("rst_busy", 128'(fif.busy), 128'(0));
        chk("rst_req", 128'(fif.bus_req), 128'(0));
        chk("rst_addr", 128'(fif.bus_addr), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Zero-wait fill, data = address
        wv = '{0, 0, 0, 0};
        do_fill(32'h0040_1238, 32'h0, 1'b0);
        chk("tp_line", fif.mem_data, 128'h0040123C_00401238_00401234_00401230);
        post_fill(1'b0, 1'b1);

        // Three wait cycles on word 2
        wv = '{0, 0, 3, 0};
        do_fill(32'h0040_1238, 32'h0, 1'b0);
        post_fill(1'b0, 1'b0);

        // Word 1 never acknowledged
        wv = '{0, 99, 0, 0};
        do_fill(32'h0040_1238, 32'h0, 1'b0);
        chk("to_line", fif.mem_data, 128'h00000000_00000000_00000000_00401230);
        post_fill(1'b0, 1'b1);

        // Back-to-back with mem_r held through DONE and COOL
        wv = '{0, 1, 0, 2};
        do_fill(32'h8000_0010, 32'h5A5A_0F0F, 1'b0);
        post_fill(1'b1, 1'b1);
        wv = '{1, 0, 0, 0};
        do_fill(32'h0000_0FF4, 32'h1111_2222, 1'b0);
        post_fill(1'b0, 1'b0);

        // Async reset after word 1 acked
        fif.mem_r    = 1'b1;
        fif.mem_addr = 32'h1234_5670;
        @(posedge clk);
        @(negedge clk);
        fif.bus_ack = 1'b1; fif.bus_rdata = 32'hAAAA_0000;
        @(negedge clk);
        fif.bus_ack = 1'b1; fif.bus_rdata = 32'hAAAA_0004;
        @(negedge clk);
        fif.bus_ack = 1'b0;
        chk("pre_rst_busy", 128'(fif.busy), 128'(1));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_req", 128'(fif.bus_req), 128'(0));
        chk("mid_rst_ready", 128'(fif.mem_ready), 128'(0));
        chk("mid_rst_busy", 128'(fif.busy), 128'(0));
        chk("mid_rst_data", fif.mem_data, 128'(0));
        chk("mid_rst_addr", 128'(fif.bus_addr), 128'(0));
        last_line = '0;
        fif.mem_r = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wv = '{0, 0, 0, 0};
        do_fill(32'h1234_5670, 32'h0, 1'b0);
        post_fill(1'b0, 1'b0);

        // Randomized fills, including timeouts, held and dropped mem_r
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            s = $urandom;
            for (int k = 0; k < 4; k++)
                wv[k] = ($urandom_range(0, 11) == 0) ? int'($urandom_range(4, 6))
                                                     : int'($urandom_range(0, 3));
            hold = ($urandom_range(0, 3) == 0);
            drop = !hold && ($urandom_range(0, 1) == 1);
            do_fill(a, s, drop);
            post_fill(hold, $urandom_range(0, 1) == 1);
        end
        fif.mem_r = 1'b0;
        @(negedge clk);
        chk("end_idle", 128'(fif.busy), 128'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
